// File: rtl/seq_div_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Optional signed mode is enabled with the SEQ_DIV_SIGNED_EN macro.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int unsigned MAX_WIDTH = 64;

    // Quotient reported for a zero divisor: all ones in the low 'width' bits.
    function automatic logic [MAX_WIDTH-1:0] div_by_zero_q(input int unsigned width);
        logic [MAX_WIDTH-1:0] ones;
        ones = '0;
        for (int unsigned i = 0; i < MAX_WIDTH; i++) begin
            if (i < width) begin
                ones[i] = 1'b1;
            end
        end
        return ones;
    endfunction

endpackage

// File: rtl/seq_div_rem_if.sv
// Operand/result handshake bundle for seq_div_rem.
// The signed_op signal exists only when SEQ_DIV_SIGNED_EN is defined.
interface seq_div_rem_if #(
    parameter int unsigned WIDTH = 4
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
`ifdef SEQ_DIV_SIGNED_EN
    logic             signed_op;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic             div_by_zero;

`ifdef SEQ_DIV_SIGNED_EN
    modport master (
        output in_valid, a, b, signed_op, out_ready,
        input  in_ready, out_valid, q, r, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, signed_op, out_ready,
        output in_ready, out_valid, q, r, div_by_zero
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, q, r, div_by_zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, q, r, div_by_zero
    );
`endif

endinterface

// File: rtl/seq_div_rem_div_step.sv
// One restoring-division step: shift {rem,quo} left, subtract the divisor
// if it fits and shift a 1 into the quotient.
module div_step #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   rem_next,
    output logic [WIDTH-1:0] quo_next
);

    localparam int unsigned RW = WIDTH + 1;

    logic [RW-1:0]    rem_sh;
    logic [WIDTH-1:0] quo_sh;
    logic [RW:0]      trial;

    always_comb begin
        rem_sh   = RW'({rem, quo[WIDTH-1]});
        quo_sh   = {quo[WIDTH-2:0], 1'b0};
        trial    = {1'b0, rem_sh} - {2'b00, b};
        rem_next = rem_sh;
        quo_next = quo_sh;
        // Top bit of trial is the borrow: clear means the divisor fit.
        if (!trial[RW]) begin
            rem_next = RW'(trial);
            quo_next = quo_sh | WIDTH'(1);
        end
    end

endmodule

// File: rtl/seq_div_rem.sv
// Multi-cycle restoring divider producing q = a / b and r = a % b, one quotient
// bit per clock. Define SEQ_DIV_SIGNED_EN to add two's-complement operation.
module seq_div_rem
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = 4
) (
    input logic          clk,
    input logic          rst_n,
    seq_div_rem_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned RW    = WIDTH + 1;

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [RW-1:0]    rem, rem_nxt;
    logic [WIDTH-1:0] quo, quo_nxt;
    logic [WIDTH-1:0] dvs, dvs_nxt;
    logic [WIDTH-1:0] quot, quot_nxt;
    logic [WIDTH-1:0] remd, remd_nxt;
    logic             dbz, dbz_nxt;
    logic             out_valid, out_valid_nxt;
    logic             in_ready, in_ready_nxt;

    logic [RW-1:0]    rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;

`ifdef SEQ_DIV_SIGNED_EN
    logic sgn, sgn_nxt;
    logic neg_q, neg_q_nxt;
    logic neg_r, neg_r_nxt;
    logic neg_a;
    logic neg_b;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .quo      (quo),
        .b        (dvs),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    // Operand magnitudes fed into the unsigned core.
    always_comb begin
`ifdef SEQ_DIV_SIGNED_EN
        neg_a = bus.signed_op & bus.a[WIDTH-1];
        neg_b = bus.signed_op & bus.b[WIDTH-1];
        a_mag = neg_a ? (WIDTH'(0) - bus.a) : bus.a;
        b_mag = neg_b ? (WIDTH'(0) - bus.b) : bus.b;
`else
        a_mag = bus.a;
        b_mag = bus.b;
`endif
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        rem_nxt       = rem;
        quo_nxt       = quo;
        dvs_nxt       = dvs;
        quot_nxt      = quot;
        remd_nxt      = remd;
        dbz_nxt       = dbz;
        out_valid_nxt = out_valid;
`ifdef SEQ_DIV_SIGNED_EN
        sgn_nxt       = sgn;
        neg_q_nxt     = neg_q;
        neg_r_nxt     = neg_r;
`endif

        case (state)
            IDLE: begin
                if (bus.in_valid && in_ready) begin
                    if (bus.b == '0) begin
                        state_nxt = DONE;
                        quot_nxt  = WIDTH'(div_by_zero_q(WIDTH));
                        remd_nxt  = bus.a;
                        dbz_nxt   = 1'b1;
                    end else begin
                        state_nxt = BUSY;
                        cnt_nxt   = CNT_W'(WIDTH);
                        rem_nxt   = '0;
                        quo_nxt   = a_mag;
                        dvs_nxt   = b_mag;
                        dbz_nxt   = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
                        sgn_nxt   = bus.signed_op;
                        neg_q_nxt = neg_a ^ neg_b;
                        neg_r_nxt = neg_a;
`endif
                    end
                end
            end

            BUSY: begin
                rem_nxt = rem_step;
                quo_nxt = quo_step;
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    quot_nxt = quo_step;
                    remd_nxt = WIDTH'(rem_step);
`ifdef SEQ_DIV_SIGNED_EN
                    if (sgn) begin
                        state_nxt = FIX;
                    end else begin
                        state_nxt     = DONE;
                        out_valid_nxt = 1'b1;
                    end
`else
                    state_nxt     = DONE;
                    out_valid_nxt = 1'b1;
`endif
                end
            end

            FIX: begin
`ifdef SEQ_DIV_SIGNED_EN
                // Quotient truncates toward zero; remainder follows the dividend's sign.
                quot_nxt      = neg_q ? (WIDTH'(0) - quot) : quot;
                remd_nxt      = neg_r ? (WIDTH'(0) - remd) : remd;
                state_nxt     = DONE;
                out_valid_nxt = 1'b1;
`else
                state_nxt     = IDLE;
`endif
            end

            DONE: begin
                // Zero-divisor results enter DONE one cycle before they are shown.
                if (!out_valid) begin
                    out_valid_nxt = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_nxt = 1'b0;
                    state_nxt     = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        in_ready_nxt = (state_nxt == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            rem       <= '0;
            quo       <= '0;
            dvs       <= '0;
            quot      <= '0;
            remd      <= '0;
            dbz       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
`ifdef SEQ_DIV_SIGNED_EN
            sgn       <= 1'b0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            rem       <= rem_nxt;
            quo       <= quo_nxt;
            dvs       <= dvs_nxt;
            quot      <= quot_nxt;
            remd      <= remd_nxt;
            dbz       <= dbz_nxt;
            out_valid <= out_valid_nxt;
            in_ready  <= in_ready_nxt;
`ifdef SEQ_DIV_SIGNED_EN
            sgn       <= sgn_nxt;
            neg_q     <= neg_q_nxt;
            neg_r     <= neg_r_nxt;
`endif
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.q           = quot;
    assign bus.r           = remd;
    assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_div_rem.sv
// Self-checking bench for seq_div_rem (WIDTH=4): directed table, hold/abort
// sequences and an exhaustive randomly-paced sweep through a result scoreboard.
module tb_seq_div_rem;

    localparam int unsigned W = 4;

    typedef struct {
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
    } res_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic       sgn;
        logic [3:0] q;
        logic [3:0] r;
        logic       dbz;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seq_div_rem_if #(.WIDTH(W)) bus ();

    seq_div_rem #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    res_t sb[$];
    vec_t tbl[$];
    int   tests   = 0;
    int   fails   = 0;
    int   pushes  = 0;
    int   results = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic res_t model(input logic [3:0] a, input logic [3:0] b, input logic sgn);
        res_t m;
        int   sa;
        int   sbv;
        if (b == 4'd0) begin
            m.q   = 4'hF;
            m.r   = a;
            m.dbz = 1'b1;
        end else if (sgn) begin
            sa    = int'($signed(a));
            sbv   = int'($signed(b));
            m.q   = 4'(sa / sbv);
            m.r   = 4'(sa % sbv);
            m.dbz = 1'b0;
        end else begin
            m.q   = a / b;
            m.r   = a % b;
            m.dbz = 1'b0;
        end
        return m;
    endfunction

    // Result monitor: a handshake happens at the next posedge when both are high here.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: q=%0h r=%0h with nothing pending", bus.q, bus.r);
            end else begin
                res_t e;
                e = sb.pop_front();
                check("sb_q", 32'(bus.q), 32'(e.q));
                check("sb_r", 32'(bus.r), 32'(e.r));
                check("sb_dbz", 32'(bus.div_by_zero), 32'(e.dbz));
                results++;
            end
        end
    end

    // Called at a negedge with in_ready high; returns at the negedge after the accept edge.
    task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic sgn, input logic push);
        check("in_ready_before_accept", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
`ifdef SEQ_DIV_SIGNED_EN
        bus.signed_op = sgn;
`endif
        if (push) begin
            sb.push_back(model(a, b, sgn));
            pushes++;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!bus.out_valid && lat < 30) begin
            @(negedge clk);
            lat++;
        end
        if (!bus.out_valid) begin
            tests++;
            fails++;
            $display("FAIL wait_out_valid: got timeout expected out_valid within 30 cycles");
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation time limit expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   lat;
        int   seen;
        int   k;
        logic sgn_v;
        logic stuck;

        tbl.push_back('{4'd13, 4'd3,  1'b0, 4'd4,  4'd1, 1'b0, 4});
        tbl.push_back('{4'd5,  4'd0,  1'b0, 4'hF,  4'd5, 1'b1, 1});
        tbl.push_back('{4'd0,  4'd7,  1'b0, 4'd0,  4'd0, 1'b0, 4});
        tbl.push_back('{4'd15, 4'd15, 1'b0, 4'd1,  4'd0, 1'b0, 4});
        tbl.push_back('{4'd7,  4'd9,  1'b0, 4'd0,  4'd7, 1'b0, 4});
        tbl.push_back('{4'd8,  4'd3,  1'b0, 4'd2,  4'd2, 1'b0, 4});
        tbl.push_back('{4'd0,  4'd0,  1'b0, 4'hF,  4'd0, 1'b1, 1});
`ifdef SEQ_DIV_SIGNED_EN
        tbl.push_back('{4'h9,  4'd2,  1'b1, 4'hD,  4'hF, 1'b0, 5});
        tbl.push_back('{4'h8,  4'hF,  1'b1, 4'h8,  4'd0, 1'b0, 5});
        tbl.push_back('{4'h9,  4'd2,  1'b0, 4'd4,  4'd1, 1'b0, 4});
        tbl.push_back('{4'd7,  4'hE,  1'b1, 4'hD,  4'd1, 1'b0, 5});
        tbl.push_back('{4'hF,  4'd0,  1'b1, 4'hF,  4'hF, 1'b1, 1});
`endif

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
`ifdef SEQ_DIV_SIGNED_EN
        bus.signed_op = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_q", 32'(bus.q), 32'd0);
        check("reset_r", 32'(bus.r), 32'd0);
        check("reset_dbz", 32'(bus.div_by_zero), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table with out_ready held high.
        bus.out_ready = 1'b1;
        foreach (tbl[i]) begin
            start_op(tbl[i].a, tbl[i].b, tbl[i].sgn, 1'b1);
            wait_valid(lat);
            check("tbl_latency", 32'(lat), 32'(tbl[i].lat));
            check("tbl_q", 32'(bus.q), 32'(tbl[i].q));
            check("tbl_r", 32'(bus.r), 32'(tbl[i].r));
            check("tbl_dbz", 32'(bus.div_by_zero), 32'(tbl[i].dbz));
            @(negedge clk);
            check("tbl_out_valid_cleared", 32'(bus.out_valid), 32'd0);
            check("tbl_back_to_idle", 32'(bus.in_ready), 32'd1);
        end

        // Result held under back-pressure; new operands offered meanwhile are ignored.
        bus.out_ready = 1'b0;
        start_op(4'd15, 4'd1, 1'b0, 1'b1);
        wait_valid(lat);
        check("hold_latency", 32'(lat), 32'd4);
        bus.in_valid = 1'b1;
        bus.a        = 4'd3;
        bus.b        = 4'd3;
        repeat (6) begin
            @(negedge clk);
            check("hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("hold_q", 32'(bus.q), 32'd15);
            check("hold_r", 32'(bus.r), 32'd0);
            check("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("hold_released_valid", 32'(bus.out_valid), 32'd0);
        check("hold_released_idle", 32'(bus.in_ready), 32'd1);

        // Reset during the second division step aborts the operation.
        start_op(4'd9, 4'd2, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_q", 32'(bus.q), 32'd0);
        check("abort_r", 32'(bus.r), 32'd0);
        rst_n = 1'b1;
        seen  = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("abort_no_result", 32'(seen), 32'd0);

        // Every operand pair with random input gaps and random consumer stalls.
        stuck = 1'b0;
        for (int a = 0; a < 16 && !stuck; a++) begin
            for (int b = 0; b < 16 && !stuck; b++) begin
                sgn_v = 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
                sgn_v = 1'($urandom_range(0, 1));
`endif
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    bus.out_ready = 1'($urandom_range(0, 1));
                end
                k = 0;
                while (!bus.in_ready && k < 200) begin
                    @(negedge clk);
                    bus.out_ready = 1'($urandom_range(0, 1));
                    k++;
                end
                if (!bus.in_ready) begin
                    tests++;
                    fails++;
                    $display("FAIL sweep_in_ready: got timeout expected in_ready within 200 cycles");
                    stuck = 1'b1;
                end else begin
                    start_op(4'(a), 4'(b), sgn_v, 1'b1);
                end
            end
        end

        bus.out_ready = 1'b1;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        check("sweep_queue_drained", 32'(sb.size()), 32'd0);
        check("one_result_per_accept", 32'(results), 32'(pushes));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
